// File: rtl/seq_mult_radix.sv
// seq_mult_radix
//   Sequential N x N -> 2N multiplier that retires R multiplier bits per
//   clock, with valid/ready handshakes on both sides and output backpressure.
//   Latency is N/R clock edges from the accepting edge to out_valid.
//
// Optional feature macro: SEQ_MULT_RADIX_SIGNED_EN
//   Adds the signed_mode input. When it is high at the input handshake, a and
//   b are two's-complement. Their magnitudes are multiplied, and one extra NEG
//   cycle applies the sign, so latency becomes N/R+1.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a = multiplicand, b = multiplier)
//   out_valid/out_ready result handshake; prod holds until it is accepted
//   prod                2N-bit product, never shows intermediate sums
//   busy                high while an operation is in flight or held
//   state               debug view: IDLE=0 RUN=1 DONE=2 (NEG=3 signed build)

module seq_mult_radix #(
    parameter int unsigned N = 256,
    parameter int unsigned R = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef SEQ_MULT_RADIX_SIGNED_EN
    input  logic           signed_mode,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] prod,
    output logic           busy,
    output logic [1:0]     state
);

    localparam int unsigned STEPS = N / R;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    if ((N % R) != 0) begin : g_bad_div
        $error("seq_mult_radix: N must be a multiple of R");
    end
    if (R < 1 || R > 8) begin : g_bad_r
        $error("seq_mult_radix: R must be in 1..8");
    end
    if (N < 8) begin : g_bad_n
        $error("seq_mult_radix: N must be at least 8");
    end

`ifdef SEQ_MULT_RADIX_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, NEG = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t         state_q, state_d;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           last_step;

    logic [N+R-1:0]   pp;
    logic [N+R-1:0]   hi_sum;
    logic [2*N+R-1:0] shifted;
    logic [2*N-1:0]   acc_next;

`ifdef SEQ_MULT_RADIX_SIGNED_EN
    logic           sgn_q;   // operation needs the NEG pass
    logic           neg_q;   // operand signs differ
    logic [N-1:0]   a_mag, b_mag;
    assign a_mag = (signed_mode && a[N-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_mode && b[N-1]) ? (~b + 1'b1) : b;
`endif

    // Right-shifting accumulator: each digit's partial product is added into
    // the upper half and the whole register shifts down by R. After N/R steps
    // the register holds the full product with no wider shifter needed.
    assign pp        = {{R{1'b0}}, mcand} * {{N{1'b0}}, mplier[R-1:0]};
    assign hi_sum    = {{R{1'b0}}, acc[2*N-1:N]} + pp;
    assign shifted   = {hi_sum, acc[N-1:0]};
    assign acc_next  = shifted[2*N+R-1:R];
    assign last_step = (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
`ifdef SEQ_MULT_RADIX_SIGNED_EN
                    state_d = sgn_q ? NEG : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SEQ_MULT_RADIX_SIGNED_EN
            NEG: begin
                busy    = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod   <= '0;
`ifdef SEQ_MULT_RADIX_SIGNED_EN
            sgn_q  <= 1'b0;
            neg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
`ifdef SEQ_MULT_RADIX_SIGNED_EN
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        sgn_q  <= signed_mode;
                        neg_q  <= signed_mode & (a[N-1] ^ b[N-1]);
`else
                        mcand  <= a;
                        mplier <= b;
`endif
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> R;
                    cnt    <= cnt + 1'b1;
`ifdef SEQ_MULT_RADIX_SIGNED_EN
                    if (last_step && !sgn_q) prod <= acc_next;
`else
                    if (last_step) prod <= acc_next;
`endif
                end
`ifdef SEQ_MULT_RADIX_SIGNED_EN
                NEG: begin
                    prod <= neg_q ? (~acc + 1'b1) : acc;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule
